// File: rtl/prog_loader.sv
// Byte-stream program loader: receives a framed image over valid/ready, packs big-endian
// words into the unified memory's write port and keeps the core held until a clean load.
module prog_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          TIMEOUT   = 1000
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_COUNT,
        S_DATA,
        S_WRITE,
        S_CHECK
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remaining;
    logic [1:0]        r_byte_cnt;
    logic [31:0]       r_word;
    logic [7:0]        r_csum;
    logic [TMO_W-1:0]  r_tmo;

    logic w_accept;
    logic w_tmo_hit;
    logic [31:0] w_word_next;

    assign w_accept    = rx_valid && rx_ready;
    assign w_tmo_hit   = !w_accept && (r_tmo == TMO_W'(TIMEOUT - 1));
    assign w_word_next = {r_word[23:0], rx_data};

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_byte_cnt   <= '0;
            r_word       <= '0;
            r_csum       <= '0;
            r_tmo        <= '0;
            rx_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            load_done <= 1'b0;
            mem_we    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    rx_ready <= 1'b1;
                    r_tmo    <= '0;
                    if (w_accept && rx_data == SYNC_BYTE) begin
                        r_state      <= S_ADDR;
                        cpu_hold     <= 1'b1;
                        load_err     <= 1'b0;
                        words_loaded <= '0;
                        r_csum       <= '0;
                    end
                end
                S_ADDR, S_COUNT, S_DATA, S_CHECK: begin
                    if (w_accept) begin
                        r_tmo <= '0;
                        case (r_state)
                            S_ADDR: begin
                                r_addr  <= ADDR_W'(rx_data);
                                r_state <= S_COUNT;
                            end
                            S_COUNT: begin
                                // A zero count means a full memory image.
                                r_remaining <= (rx_data == 8'd0) ? {1'b1, {ADDR_W{1'b0}}}
                                                                 : (ADDR_W + 1)'(rx_data);
                                r_byte_cnt  <= '0;
                                r_state     <= S_DATA;
                            end
                            S_DATA: begin
                                r_word     <= w_word_next;
                                r_csum     <= r_csum ^ rx_data;
                                r_byte_cnt <= r_byte_cnt + 2'd1;
                                if (r_byte_cnt == 2'd3) begin
                                    r_state   <= S_WRITE;
                                    rx_ready  <= 1'b0;
                                    mem_we    <= 1'b1;
                                    mem_addr  <= r_addr;
                                    mem_wdata <= w_word_next;
                                end
                            end
                            default: begin
                                if (rx_data == r_csum) begin
                                    load_done <= 1'b1;
                                    cpu_hold  <= 1'b0;
                                end else begin
                                    load_err  <= 1'b1;
                                end
                                r_state <= S_IDLE;
                            end
                        endcase
                    end else if (w_tmo_hit) begin
                        load_err <= 1'b1;
                        r_tmo    <= '0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_WRITE: begin
                    // The idle counter is frozen here; the write slot is not sender idle time.
                    rx_ready     <= 1'b1;
                    r_addr       <= r_addr + 1'b1;
                    r_remaining  <= r_remaining - 1'b1;
                    words_loaded <= words_loaded + 1'b1;
                    r_state      <= (r_remaining == (ADDR_W + 1)'(1)) ? S_CHECK : S_DATA;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Byte-stream program loader: the writer side of the processor's 256x32 unified memory, which the pipeline reads.
- Receives a framed program image over a valid/ready byte interface.
- Assembles big-endian 32-bit words and writes them into memory through a dedicated write port.
- Holds the core frozen via cpu_hold until a frame loads with a correct checksum.

Parameters:
ADDR_W, 8, memory word-address width (256 words); addresses wrap modulo 2^ADDR_W
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT, 1000, max idle cycles between accepted bytes inside a frame (>=2)

Ports:
clk1  input  1  single clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader can accept a byte
mem_we  output  1  memory write strobe, one cycle per word
mem_addr  output  ADDR_W  write word address
mem_wdata  output  32  write data
cpu_hold  output  1  1 = processor must stay stalled
load_done  output  1  one-cycle pulse on successful load
load_err  output  1  sticky error flag
words_loaded  output  ADDR_W+1  words written in current/last frame

Behaviour:
- Byte transfer: a byte is accepted when rx_valid && rx_ready on a clk1 edge.
- Reset values while reset=0: state IDLE; rx_ready=0; mem_we=0; mem_addr=0; mem_wdata=0; cpu_hold=1; load_done=0; load_err=0; words_loaded=0. rx_ready goes to 1 on the first edge after release.
- Frame format: SYNC_BYTE, start address, count (0 encodes 2^ADDR_W), count×4 data bytes MSB first, checksum. Checksum = XOR of all data bytes only.
- States: IDLE, ADDR, COUNT, DATA, WRITE, CHECK.
- IDLE: rx_ready=1. Non-sync bytes are consumed and discarded. SYNC_BYTE -> ADDR; same edge sets cpu_hold=1, clears load_err, zeroes words_loaded and the checksum accumulator.
- ADDR: accepted byte loads the address register -> COUNT.
- COUNT: accepted byte loads the remaining count (0 -> 2^ADDR_W) -> DATA; byte counter cleared.
- DATA:
  - Each accepted byte shifts into the word register (first byte lands in [31:24]) and XORs into the accumulator.
  - The 4th byte -> WRITE.
- WRITE (exactly one cycle):
  - rx_ready=0; mem_we=1; mem_addr=address register; mem_wdata=assembled word.
  - Next edge: address+1 mod 2^ADDR_W, remaining-1, words_loaded+1.
  - Then remaining==0 -> CHECK, else DATA.
  - Latency: 4th data byte accepted at edge N, mem_we high during cycle N+1.
- CHECK: accepted byte compared with the accumulator.
  - Match: load_done=1 for one cycle; cpu_hold=0 from the next cycle.
  - Mismatch: load_err=1; cpu_hold stays 1.
  - Either way -> IDLE.
- Memory writes are not rolled back on a checksum error; the core stays held.
- Timeout: in ADDR/COUNT/DATA/CHECK, a counter increments each cycle without an accepted byte and clears on each accepted byte.
  - Reaching TIMEOUT -> load_err=1, IDLE, cpu_hold stays 1.
  - WRITE neither counts nor clears the counter.
- A SYNC_BYTE value received inside a frame is treated as data (no resync).
- mem_addr/mem_wdata hold their last values when mem_we=0.
- Reset asserted mid-frame: immediate return to reset values; no further writes; partial frame abandoned.
- Back-to-back frames are allowed. cpu_hold re-asserts on the next sync even after a successful load.

Test Plan:
1. Normal load: send A5,10,02,18,41,00,05,FC,00,00,00,A0 with rx_valid held high -> mem_we at addr 0x10 data 0x18410005, then at 0x11 data 0xFC000000; load_done pulses once; cpu_hold falls; words_loaded=2; load_err=0.
2. Count 0 with wrap: A5,FF,00 followed by 256 words of value i -> first write at addr 0xFF, second at 0x00, last at 0xFE; words_loaded=256; done only if checksum correct.
3. Bad checksum: case 1 with final byte 0xA1 -> both writes occur; load_err=1, no load_done, cpu_hold stays 1. A following correct frame clears load_err and drops cpu_hold.
4. Timeout: A5,10,02,18 then rx_valid=0 for TIMEOUT cycles -> load_err=1, no mem_we, state IDLE; next A5 accepted normally.
5. Junk and stalls: bytes 00,33,FF before A5, random rx_valid gaps shorter than TIMEOUT, and a data byte equal to A5 -> junk ignored; words assembled correctly; rx_ready low exactly one cycle per WRITE.
6. Reset mid-frame: assert reset after 6 data bytes -> outputs at reset values immediately, no write for the partial word; the next full frame loads correctly.
